mem_io_responder: RTL and testbench
===================================

// Module: mem_io_responder
// PURPOSE
//  Bus responder on the far side of the CPU byte memory bus (mem_a/mem_dout/mem_wr in, mem_din/io_buffer_full out).
//  Holds 128KB byte RAM; decodes the I/O window (mem_a[17:16]==2'b11).
//  Provides UART TX FIFO, RX holding byte, free-running cycle counter and program-stop sequencing.
//  Sits between cpu and the UART/host logic at the SoC top.
// PARAMETERS
//  RAM_ADDR_W   17  RAM index width (2^17 bytes)
//  TX_DEPTH_LOG 4   TX FIFO depth = 2^TX_DEPTH_LOG entries
//  FULL_MARGIN  2   io_buffer_full asserts when free entries <= FULL_MARGIN (covers CPU write latency)
// PORTS
//  clk_in        in   1   system clock
//  rst_in        in   1   synchronous reset, active-low
//  bus_en        in   1   bus access valid this cycle (tied to CPU rdy_in)
//  mem_a         in   32  byte address from CPU
//  mem_wr        in   1   1 = write, 0 = read
//  mem_wdata     in   8   write byte (CPU mem_dout)
//  mem_rdata     out  8   read byte (CPU mem_din), registered
//  io_buffer_full out 1   TX FIFO nearly full
//  tx_data       out  8   byte to UART transmitter
//  tx_valid      out  1   tx_data valid (FIFO non-empty)
//  tx_ready      in   1   UART accepts tx_data this cycle
//  rx_data       in   8   received byte
//  rx_valid      in   1   rx_data valid
//  rx_ready      out  1   holding register empty
//  prog_done     out  1   sticky: stop sequence complete
// BEHAVIOUR
//  Reset (rst_in==0 at edge): mem_rdata=0, io_buffer_full=0, tx_valid=0, rx_ready=1, prog_done=0,
//   FIFO ptrs/count=0, cycle counter=0, snapshot=0, state=RUN. RAM contents not cleared.
//  Reset mid-operation: in-flight FIFO bytes discarded; no tx_valid in cycle after reset.
//  Cycle counter: 32-bit, +1 every cycle out of reset, wraps 0xFFFFFFFF->0, ignores bus_en.
//  Decode: io = mem_a[17:16]==2'b11; RAM index = mem_a[RAM_ADDR_W-1:0].
//  Bus accesses act only when bus_en=1; bus_en=0 -> no state change except counter, FIFO pop, RX capture.
//  RAM read: mem_rdata = ram[idx] one cycle after request. RAM write: updates at the edge; a read next cycle returns new byte.
//  IO read 0x30000: returns held RX byte and clears holder; returns 0x00 if empty.
//  IO read 0x30004: returns counter[7:0] and latches the full counter into snapshot.
//  IO read 0x30005..7: returns snapshot byte 1..3 (coherent dword).
//  Other IO reads return 0x00.
//  Side-effecting IO reads: CPU presents each such address for exactly one bus_en cycle.
//  IO write 0x30000: data!=0 pushes FIFO; data==0 ignored.
//  IO write 0x30004: enters stop sequence.
//  Other IO writes are ignored.
//  TX FIFO: circular, ptrs wrap modulo depth, count TX_DEPTH_LOG+1 bits.
//   Pop when tx_valid&tx_ready. Simultaneous push+pop: count unchanged, both ptrs advance.
//   Push when count==depth (no pop): byte dropped.
//   io_buffer_full is registered: 1 when (depth-count) <= FULL_MARGIN after this edge.
//  RX: capture rx_data when rx_valid&rx_ready. Capture and pop in same cycle: pop returns old byte, new byte held.
//  Stop FSM:
//   RUN -(write 0x30004)-> DRAIN: forces push of 0x00 (dropped only if FIFO full).
//   DRAIN -(count==0)-> DONE: prog_done=1 sticky.
//   In DRAIN/DONE all IO writes are ignored; reads still serviced.
// STRUCTURE
//  Shared package: IO_BASE=32'h30000, IO_UART=2'd0, IO_CLK=2'd1 (offset>>2), stop FSM state enum.
//  Sub-module: byte_fifo (param width/depth; push/pop/count). RAM as inferred reg array (single port, registered read).
// TESTING
//  Write 0xAB to 0x00100, read 0x00100 next cycle -> mem_rdata==0xAB one cycle after read.
//  Hold tx_ready=0, write 0x41 x16 -> io_buffer_full=1 after 14th push; 17th write dropped; tx_ready=1 drains 16 bytes in order.
//  Write 0x00 to 0x30000 -> no push, tx_valid stays 0.
//  rx_valid with 0x5A, read 0x30000 -> 0x5A; second read -> 0x00, rx_ready=1.
//  Counter=0x12345678 at read 0x30004 -> bytes 0x78, then 0x56/0x34/0x12 from 0x30005-7 despite counter advancing.
//  Write 0x30004 with 3 bytes queued -> 0x00 emitted last, prog_done=1 once FIFO empty; later writes ignored;
//   rst_in=0 mid-DRAIN clears all outputs.

Source files
------------

// File: rtl/mem_io_responder_pkg.sv
// rtl/mem_io_responder_pkg.sv - shared I/O map constants and stop-sequence state type
package mem_io_responder_pkg;

    // I/O window base; registers are selected by word offset (byte offset >> 2)
    localparam logic [31:0] IO_BASE = 32'h0003_0000;
    localparam logic [1:0]  IO_UART = 2'd0;
    localparam logic [1:0]  IO_CLK  = 2'd1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } stop_state_t;

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// rtl/mem_io_responder_byte_fifo.sv - circular byte FIFO with push/pop and occupancy count
//
// Ports:
//   clk, resetn         clock, synchronous active-low reset (pointers/count only)
//   push, push_data     write request; dropped when full unless a pop happens too
//   pop                 read request; ignored when empty
//   pop_data            entry at the read pointer (valid when count != 0)
//   count               current occupancy
//   count_next          occupancy after this edge, for registered threshold flags
module mem_io_responder_byte_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     pop_data,
    output logic [DEPTH_LOG:0]   count,
    output logic [DEPTH_LOG:0]   count_next
);

    localparam logic [DEPTH_LOG:0] DEPTH_N = {1'b1, {DEPTH_LOG{1'b0}}};

    logic [WIDTH-1:0]     mem [0:(1<<DEPTH_LOG)-1];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_pop;
    logic                 do_push;

    assign do_pop   = pop && (count != '0);
    // A full FIFO still accepts a push when an entry leaves in the same cycle
    assign do_push  = push && ((count != DEPTH_N) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - CPU byte-bus responder: RAM, UART TX FIFO / RX holder, cycle counter, stop sequencing
//
// Ports:
//   clk_in, rst_in                  clock, synchronous active-low reset
//   bus_en, mem_a, mem_wr, mem_wdata  CPU byte access (acts only when bus_en=1)
//   mem_rdata                       registered read byte, one cycle after the request
//   io_buffer_full                  TX FIFO nearly full (registered)
//   tx_data, tx_valid, tx_ready     byte stream to the UART transmitter
//   rx_data, rx_valid, rx_ready     byte from the UART receiver into the holding register
//   prog_done                       sticky: stop sequence drained the TX FIFO
module mem_io_responder
    import mem_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W   = 17,
    parameter int TX_DEPTH_LOG = 4,
    parameter int FULL_MARGIN  = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        bus_en,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        prog_done
);

    localparam logic [TX_DEPTH_LOG:0] FULL_LEVEL =
        (TX_DEPTH_LOG+1)'((1 << TX_DEPTH_LOG) - FULL_MARGIN);

    logic [7:0]             ram [0:(1<<RAM_ADDR_W)-1];
    logic [RAM_ADDR_W-1:0]  ram_idx;
    logic                   io;
    logic                   uart_sel;
    logic                   clk_sel;
    logic [1:0]             io_byte;
    logic                   rd_req;
    logic                   wr_req;
    logic                   rx_pop;
    logic                   rx_capture;
    logic                   rx_full;
    logic [7:0]             rx_byte;
    logic [31:0]            cycle_cnt;
    logic [31:0]            snapshot;
    logic [7:0]             io_rdata;
    logic                   stop_wr;
    logic                   fifo_push;
    logic [7:0]             fifo_push_data;
    logic [TX_DEPTH_LOG:0]  tx_count;
    logic [TX_DEPTH_LOG:0]  tx_count_next;
    stop_state_t            state;
    stop_state_t            state_next;
    logic                   unused_addr_bits;

    // Address bits above the I/O window select are don't-care
    assign unused_addr_bits = ^mem_a[31:18];

    assign io       = (mem_a[17:16] == 2'b11);
    assign ram_idx  = mem_a[RAM_ADDR_W-1:0];
    assign io_byte  = mem_a[1:0];
    assign uart_sel = io && (mem_a[15:4] == IO_BASE[15:4]) && (mem_a[3:2] == IO_UART) && (io_byte == 2'd0);
    assign clk_sel  = io && (mem_a[15:4] == IO_BASE[15:4]) && (mem_a[3:2] == IO_CLK);
    assign rd_req   = bus_en && !mem_wr;
    assign wr_req   = bus_en && mem_wr;
    assign rx_pop   = rd_req && uart_sel;
    assign stop_wr  = wr_req && clk_sel && (io_byte == 2'd0);

    assign rx_ready   = !rx_full;
    assign rx_capture = rx_valid && !rx_full;
    assign tx_valid   = (tx_count != '0);
    assign prog_done  = (state == ST_DONE);

    // Byte 0 of the clock register reads live and latches the snapshot, so
    // bytes 1..3 read afterwards come from the same counter value.
    always_comb begin
        io_rdata = 8'h00;
        if (uart_sel) begin
            io_rdata = rx_full ? rx_byte : 8'h00;
        end else if (clk_sel) begin
            case (io_byte)
                2'd0:    io_rdata = cycle_cnt[7:0];
                2'd1:    io_rdata = snapshot[15:8];
                2'd2:    io_rdata = snapshot[23:16];
                default: io_rdata = snapshot[31:24];
            endcase
        end
    end

    always_comb begin
        state_next     = state;
        fifo_push      = 1'b0;
        fifo_push_data = mem_wdata;
        case (state)
            ST_RUN: begin
                if (stop_wr) begin
                    // A trailing 0x00 tells the host the program has ended
                    state_next     = ST_DRAIN;
                    fifo_push      = 1'b1;
                    fifo_push_data = 8'h00;
                end else if (wr_req && uart_sel && (mem_wdata != 8'h00)) begin
                    fifo_push = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (tx_count == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_DONE;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    mem_io_responder_byte_fifo #(
        .WIDTH     (8),
        .DEPTH_LOG (TX_DEPTH_LOG)
    ) u_tx_fifo (
        .clk        (clk_in),
        .resetn     (rst_in),
        .push       (fifo_push),
        .push_data  (fifo_push_data),
        .pop        (tx_valid && tx_ready),
        .pop_data   (tx_data),
        .count      (tx_count),
        .count_next (tx_count_next)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            mem_rdata      <= 8'h00;
            io_buffer_full <= 1'b0;
            rx_full        <= 1'b0;
            rx_byte        <= 8'h00;
            cycle_cnt      <= 32'h0;
            snapshot       <= 32'h0;
        end else begin
            cycle_cnt      <= cycle_cnt + 32'd1;
            io_buffer_full <= (tx_count_next >= FULL_LEVEL);
            if (rd_req) begin
                mem_rdata <= io ? io_rdata : ram[ram_idx];
            end
            if (rd_req && clk_sel && (io_byte == 2'd0)) begin
                snapshot <= cycle_cnt;
            end
            // A capture only happens when the holder is empty, so a same-cycle
            // read returns the old (empty) value and the new byte stays held.
            if (rx_capture) begin
                rx_full <= 1'b1;
                rx_byte <= rx_data;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (wr_req && !io) begin
            ram[ram_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb/tb_mem_io_responder.sv - self-checking bench for mem_io_responder with a behavioural model
module tb_mem_io_responder;

    localparam int PERIOD = 10;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        bus_en = 1'b0;
    logic [31:0] mem_a = 32'h0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_wdata = 8'h00;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        prog_done;

    mem_io_responder dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .bus_en         (bus_en),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .prog_done      (prog_done)
    );

    always #(PERIOD/2) clk_in = ~clk_in;

    int          n_cmp  = 0;
    int          n_fail = 0;
    time         t_rst  = 0;

    // Behavioural model state
    logic [7:0]  txq[$];
    logic [7:0]  ram_m [int];
    bit          m_stop  = 1'b0;
    bit          m_done  = 1'b0;
    bit          rx_held = 1'b0;
    logic [7:0]  rx_val  = 8'h00;
    logic [31:0] m_snap  = 32'h0;
    logic [31:0] pool [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: predict the edge from the spec rules, then compare all outputs.
    task automatic step();
        bit          rd, is_io, pop, push, stop_pre, exp_known;
        int          size_pre, cval;
        logic [15:0] off;
        int          idx;
        logic [7:0]  pd, exp_rd;
        @(posedge clk_in);
        cval      = int'(($time - t_rst) / PERIOD) - 1;
        is_io     = (mem_a[17:16] == 2'b11);
        off       = mem_a[15:0];
        idx       = int'(mem_a[16:0]);
        rd        = bus_en && !mem_wr;
        size_pre  = txq.size();
        stop_pre  = m_stop;
        exp_known = 1'b0;
        exp_rd    = 8'h00;
        if (rd) begin
            exp_known = 1'b1;
            if (!is_io) begin
                exp_known = ram_m.exists(idx);
                if (exp_known) exp_rd = ram_m[idx];
            end else begin
                case (off)
                    16'h0: exp_rd = rx_held ? rx_val : 8'h00;
                    16'h4: begin exp_rd = cval[7:0]; m_snap = 32'(cval); end
                    16'h5: exp_rd = m_snap[15:8];
                    16'h6: exp_rd = m_snap[23:16];
                    16'h7: exp_rd = m_snap[31:24];
                    default: exp_rd = 8'h00;
                endcase
            end
        end
        if (bus_en && mem_wr && !is_io) ram_m[idx] = mem_wdata;
        push = 1'b0;
        pd   = 8'h00;
        if (bus_en && mem_wr && is_io && !m_stop) begin
            if (off == 16'h0 && mem_wdata != 8'h00) begin
                push = 1'b1;
                pd   = mem_wdata;
            end else if (off == 16'h4) begin
                push   = 1'b1;
                m_stop = 1'b1;
            end
        end
        pop = (size_pre > 0) && tx_ready;
        if (pop) void'(txq.pop_front());
        if (push && (size_pre < 16 || pop)) txq.push_back(pd);
        if (rx_valid && !rx_held) begin
            rx_held = 1'b1;
            rx_val  = rx_data;
        end else if (rd && is_io && off == 16'h0) begin
            rx_held = 1'b0;
        end
        if (stop_pre && size_pre == 0) m_done = 1'b1;
        #1;
        check("tx_valid", 32'(tx_valid), 32'(txq.size() > 0));
        if (txq.size() > 0) check("tx_data", 32'(tx_data), 32'(txq[0]));
        check("io_buffer_full", 32'(io_buffer_full), 32'((16 - txq.size()) <= 2));
        check("rx_ready", 32'(rx_ready), 32'(!rx_held));
        check("prog_done", 32'(prog_done), 32'(m_done));
        if (exp_known) check("mem_rdata", 32'(mem_rdata), 32'(exp_rd));
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [7:0] d);
        bus_en = 1'b1; mem_wr = 1'b1; mem_a = a; mem_wdata = d;
        step();
        bus_en = 1'b0; mem_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a);
        bus_en = 1'b1; mem_wr = 1'b0; mem_a = a;
        step();
        bus_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        @(posedge clk_in);
        t_rst = $time;
        #1;
        rst_in = 1'b1;
        txq.delete();
        m_stop = 1'b0; m_done = 1'b0; rx_held = 1'b0; m_snap = 32'h0;
        check("rst_mem_rdata", 32'(mem_rdata), 32'h0);
        check("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h1);
        check("rst_prog_done", 32'(prog_done), 32'h0);
    endtask

    initial begin
        do_reset();

        // RAM write then read-back
        bus_wr(32'h0000_0100, 8'hAB);
        bus_rd(32'h0000_0100);
        check("ram_readback", 32'(mem_rdata), 32'hAB);

        // Zero write to the UART data register is not queued
        bus_wr(32'h0003_0000, 8'h00);
        check("zero_no_push", 32'(tx_valid), 32'h0);

        // Fill the TX FIFO with the UART stalled, overflow by one, then drain
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus_wr(32'h0003_0000, 8'h41 + 8'(i));
            if (i == 12) check("full_after_13", 32'(io_buffer_full), 32'h0);
            if (i == 13) check("full_after_14", 32'(io_buffer_full), 32'h1);
        end
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_order", 32'(tx_data), 32'(8'h41 + 8'(i)));
            step();
        end
        check("drained_empty", 32'(tx_valid), 32'h0);
        check("drained_not_full", 32'(io_buffer_full), 32'h0);

        // RX holding register
        rx_data = 8'h5A; rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
        check("rx_held", 32'(rx_ready), 32'h0);
        bus_rd(32'h0003_0000);
        check("rx_read", 32'(mem_rdata), 32'h5A);
        bus_rd(32'h0003_0000);
        check("rx_read_empty", 32'(mem_rdata), 32'h0);
        check("rx_ready_again", 32'(rx_ready), 32'h1);
        // Capture during a pop of the empty holder keeps the new byte
        rx_data = 8'h77; rx_valid = 1'b1;
        bus_rd(32'h0003_0000);
        rx_valid = 1'b0;
        check("rx_same_cycle_old", 32'(mem_rdata), 32'h0);
        bus_rd(32'h0003_0000);
        check("rx_same_cycle_new", 32'(mem_rdata), 32'h77);

        // Counter snapshot coherence across a counter advance
        for (int i = 0; i < 700; i++) step();
        bus_rd(32'h0003_0004);
        for (int i = 0; i < 300; i++) step();
        bus_rd(32'h0003_0005);
        check("snap_byte1", 32'(mem_rdata), 32'(m_snap[15:8]));
        bus_rd(32'h0003_0006);
        bus_rd(32'h0003_0007);
        bus_rd(32'h0003_0010);
        check("io_other_zero", 32'(mem_rdata), 32'h0);

        // Randomized mix against the model
        for (int i = 0; i < 8; i++) begin
            pool[i] = {15'h0, 17'($urandom)};
            if (pool[i][16]) pool[i][17] = 1'b0;
            pool[i][31:18] = 14'($urandom);
            bus_wr(pool[i], 8'($urandom));
        end
        for (int i = 0; i < 400; i++) begin
            int op;
            op       = int'($urandom_range(0, 9));
            tx_ready = ($urandom_range(0, 3) == 0);
            rx_valid = ($urandom_range(0, 4) == 0);
            rx_data  = 8'($urandom);
            case (op)
                0, 1:       bus_wr(pool[$urandom_range(0, 7)], 8'($urandom));
                2, 3:       bus_rd(pool[$urandom_range(0, 7)]);
                4, 5, 6:    bus_wr(32'h0003_0000, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom));
                7:          bus_rd(32'h0003_0000 + 32'($urandom_range(0, 8)));
                default:    step();
            endcase
        end
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        for (int i = 0; i < 20 && tx_valid; i++) step();
        check("random_drained", 32'(tx_valid), 32'h0);

        // Stop sequence with three bytes queued
        tx_ready = 1'b0;
        bus_wr(32'h0003_0000, 8'h11);
        bus_wr(32'h0003_0000, 8'h22);
        bus_wr(32'h0003_0000, 8'h33);
        bus_wr(32'h0003_0004, 8'h01);
        bus_wr(32'h0003_0000, 8'h44);
        check("drain_not_done", 32'(prog_done), 32'h0);
        tx_ready = 1'b1;
        check("stop_b0", 32'(tx_data), 32'h11); step();
        check("stop_b1", 32'(tx_data), 32'h22); step();
        check("stop_b2", 32'(tx_data), 32'h33); step();
        check("stop_marker", 32'(tx_data), 32'h00);
        check("stop_marker_valid", 32'(tx_valid), 32'h1);
        for (int i = 0; i < 10 && !prog_done; i++) step();
        check("prog_done_set", 32'(prog_done), 32'h1);
        bus_wr(32'h0003_0000, 8'h55);
        check("done_write_ignored", 32'(tx_valid), 32'h0);
        bus_rd(32'h0000_0100);
        check("done_read_serviced", 32'(mem_rdata), 32'hAB);

        // Reset in the middle of draining
        do_reset();
        tx_ready = 1'b0;
        bus_wr(32'h0003_0000, 8'h66);
        bus_wr(32'h0003_0000, 8'h67);
        bus_wr(32'h0003_0004, 8'h00);
        bus_rd(32'h0000_0100);
        do_reset();
        step();
        check("post_reset_tx_valid", 32'(tx_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
